// File: rtl/fx3_gpif_requester_if.sv
// GPIF-II read-side bundle between the requester (master) and the packet transmitter (slave).
// Latency: none, this is wiring only.
// Backpressure: none, readData is the only request path and the transmitter must honour it.
interface fx3_gpif_requester_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  readData;
  logic                  fx3isReading;
  logic [DATA_WIDTH-1:0] dataIn;

  modport master (output readData, input fx3isReading, input dataIn);
  modport slave  (input readData, output fx3isReading, output dataIn);
endinterface

// File: rtl/fx3_gpif_requester.sv
// FX3 GPIF-II reader emulation: requests packets, counts and checks words against an incrementing pattern.
// Latency: readData is registered, so it changes one edge after each state decision; status updates at packet close.
// Backpressure: a new request is issued only from IDLE while enable and bufferReady (one-packet credit) are high.
module fx3_gpif_requester #(
  parameter int PACKET_WORDS   = 8192,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int DATA_WIDTH     = 16
) (
  input  logic                 fx3_clock,
  input  logic                 nReset,
  fx3_gpif_requester_if.master gpif,
  input  logic                 enable,
  input  logic                 bufferReady,
  input  logic                 clearErrors,
  output logic                 busy,
  output logic                 packetDone,
  output logic [31:0]          packetCount,
  output logic [15:0]          lastLength,
  output logic                 lengthError,
  output logic                 patternError,
  output logic                 timeoutError,
  output logic [15:0]          errorCount
);

  typedef enum logic [1:0] {IDLE, REQUEST, RECEIVE, GAP} state_t;

  state_t                state;
  state_t                stateNext;
  logic [15:0]           cycleCount;   // cycles spent in the current state
  logic [15:0]           wordCount;
  logic [DATA_WIDTH-1:0] expectedWord;
  logic                  packetPatternSeen;  // one pattern event per packet
  logic                  strayFlagged;       // one stray-word event per IDLE/GAP entry

  logic takeWord;
  logic closePacket;
  logic timeoutHit;
  logic strayHit;
  logic patternMiss;
  logic patternEvent;
  logic lengthEvent;
  logic errorEvent;

  assign busy = (state != IDLE);

  // Next-state decision plus the single-cycle events each state can raise.
  always_comb begin
    stateNext   = state;
    takeWord    = 1'b0;
    closePacket = 1'b0;
    timeoutHit  = 1'b0;
    strayHit    = 1'b0;
    case (state)
      IDLE: begin
        strayHit = gpif.fx3isReading && !strayFlagged;
        if (enable && bufferReady) stateNext = REQUEST;
      end
      REQUEST: begin
        // The word that arrives with the first fx3isReading is word 0 of the packet.
        if (gpif.fx3isReading) begin
          takeWord  = 1'b1;
          stateNext = RECEIVE;
        end else if (cycleCount == 16'(TIMEOUT_CYCLES - 1)) begin
          timeoutHit = 1'b1;
          stateNext  = GAP;
        end
      end
      RECEIVE: begin
        if (gpif.fx3isReading) begin
          takeWord = 1'b1;
        end else begin
          closePacket = 1'b1;
          stateNext   = GAP;
        end
      end
      GAP: begin
        strayHit = gpif.fx3isReading && !strayFlagged;
        if (cycleCount == 16'(GAP_CYCLES - 1)) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign patternMiss  = takeWord && (gpif.dataIn != expectedWord);
  assign patternEvent = patternMiss && !packetPatternSeen;
  assign lengthEvent  = closePacket && (wordCount != 16'(PACKET_WORDS));
  assign errorEvent   = timeoutHit || patternEvent || lengthEvent || strayHit;

  // State register, per-state cycle counter and the registered request line.
  always_ff @(posedge fx3_clock or negedge nReset) begin
    if (!nReset) begin
      state         <= IDLE;
      cycleCount    <= 16'd0;
      gpif.readData <= 1'b0;
      strayFlagged  <= 1'b0;
    end else begin
      state         <= stateNext;
      gpif.readData <= (stateNext == REQUEST);
      if (stateNext != state) begin
        cycleCount   <= 16'd0;
        strayFlagged <= 1'b0;
      end else begin
        cycleCount <= cycleCount + 16'd1;
        if (strayHit) strayFlagged <= 1'b1;
      end
    end
  end

  // Word counting, pattern tracking and packet close bookkeeping.
  always_ff @(posedge fx3_clock or negedge nReset) begin
    if (!nReset) begin
      wordCount         <= 16'd0;
      expectedWord      <= '0;
      packetPatternSeen <= 1'b0;
      packetDone        <= 1'b0;
      packetCount       <= 32'd0;
      lastLength        <= 16'd0;
    end else begin
      packetDone <= closePacket;
      if (takeWord) begin
        if (wordCount != 16'hFFFF) wordCount <= wordCount + 16'd1;
        // After a miss, resync to the received word so one glitch is one event.
        expectedWord <= patternMiss ? gpif.dataIn + DATA_WIDTH'(1) : expectedWord + DATA_WIDTH'(1);
        if (patternEvent) packetPatternSeen <= 1'b1;
      end
      if (closePacket) begin
        lastLength        <= wordCount;
        wordCount         <= 16'd0;
        packetCount       <= packetCount + 32'd1;
        packetPatternSeen <= 1'b0;
      end
    end
  end

  // Sticky error flags and saturating event counter; a new error beats a same-cycle clear.
  always_ff @(posedge fx3_clock or negedge nReset) begin
    if (!nReset) begin
      lengthError  <= 1'b0;
      patternError <= 1'b0;
      timeoutError <= 1'b0;
      errorCount   <= 16'd0;
    end else begin
      if (clearErrors) begin
        lengthError  <= 1'b0;
        patternError <= 1'b0;
        timeoutError <= 1'b0;
        errorCount   <= 16'd0;
      end
      if (lengthEvent || strayHit) lengthError <= 1'b1;
      if (patternEvent) patternError <= 1'b1;
      if (timeoutHit) timeoutError <= 1'b1;
      if (errorEvent) begin
        if (clearErrors) errorCount <= 16'd1;
        else if (errorCount != 16'hFFFF) errorCount <= errorCount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fx3_gpif_requester.sv
// Bench for fx3_gpif_requester: plays the transmitter (request-to-data latency of two edges)
// and compares the requester's status against a packet-level reference model.
module tb_fx3_gpif_requester;
  localparam int PW  = 8192;
  localparam int GAP = 4;
  localparam int TMO = 64;

  logic        fx3_clock = 1'b0;
  logic        nReset, enable, bufferReady, clearErrors;
  logic        busy, packetDone, lengthError, patternError, timeoutError;
  logic [31:0] packetCount;
  logic [15:0] lastLength, errorCount;

  fx3_gpif_requester_if #(.DATA_WIDTH(16)) gpif ();

  fx3_gpif_requester #(
    .PACKET_WORDS(PW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .DATA_WIDTH(16)
  ) dut (
    .fx3_clock(fx3_clock), .nReset(nReset), .gpif(gpif),
    .enable(enable), .bufferReady(bufferReady), .clearErrors(clearErrors),
    .busy(busy), .packetDone(packetDone), .packetCount(packetCount),
    .lastLength(lastLength), .lengthError(lengthError), .patternError(patternError),
    .timeoutError(timeoutError), .errorCount(errorCount)
  );

  always #5 fx3_clock = ~fx3_clock;

  int tests = 0;
  int fails = 0;

  // Reference model state: what the requester should report, tracked per packet.
  logic [15:0] mExp, mLast, mErr, srcWord;
  logic [31:0] mPkt;
  logic        mLenE, mPatE, mToE;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge fx3_clock);
    #1;
  endtask

  task automatic addError;
    if (mErr != 16'hFFFF) mErr = mErr + 16'd1;
  endtask

  task automatic modelReset;
    mExp = 0; mLast = 0; mErr = 0; srcWord = 0; mPkt = 0;
    mLenE = 0; mPatE = 0; mToE = 0;
  endtask

  task automatic modelClear;
    mLenE = 0; mPatE = 0; mToE = 0; mErr = 0;
  endtask

  task automatic checkStatus(input string tag);
    checkValue({tag, ".packetCount"}, packetCount, mPkt);
    checkValue({tag, ".lastLength"}, {16'd0, lastLength}, {16'd0, mLast});
    checkValue({tag, ".lengthError"}, {31'd0, lengthError}, {31'd0, mLenE});
    checkValue({tag, ".patternError"}, {31'd0, patternError}, {31'd0, mPatE});
    checkValue({tag, ".timeoutError"}, {31'd0, timeoutError}, {31'd0, mToE});
    checkValue({tag, ".errorCount"}, {16'd0, errorCount}, {16'd0, mErr});
  endtask

  // Counts edges until readData is seen high; expects exactly 'expected' edges.
  task automatic waitRequest(input int expected, input string tag);
    int cnt;
    cnt = 0;
    while (!gpif.readData && cnt < 300) begin
      tick;
      cnt++;
    end
    checkValue(tag, cnt, expected);
  endtask

  // Entered just after the edge where readData rose. Serves n words with the transmitter latency,
  // optionally corrupting one word or pulsing the shared reset at word abortAt.
  task automatic sendPacket(input int n, input int corruptIdx, input logic [15:0] corruptAdd,
                            input int abortAt);
    logic [15:0] w;
    bit hit;
    bit aborted;
    hit = 0;
    aborted = 0;
    tick;
    tick;
    checkValue("reqHold", {31'd0, gpif.readData}, 32'd1);
    for (int i = 0; i < n; i++) begin
      if (i == abortAt) begin
        gpif.fx3isReading = 1'b0;
        nReset = 1'b0;
        #2;
        modelReset();
        checkValue("rstReadData", {31'd0, gpif.readData}, 32'd0);
        checkValue("rstBusy", {31'd0, busy}, 32'd0);
        checkValue("rstPacketDone", {31'd0, packetDone}, 32'd0);
        checkStatus("rstMid");
        @(posedge fx3_clock);
        #1;
        nReset = 1'b1;
        aborted = 1;
        break;
      end
      w = srcWord;
      if (i == corruptIdx) w = w + corruptAdd;
      if (w != mExp) begin
        mPatE = 1;
        if (!hit) begin
          hit = 1;
          addError();
        end
      end
      mExp = w + 16'd1;
      srcWord = srcWord + 16'd1;
      gpif.fx3isReading = 1'b1;
      gpif.dataIn = w;
      tick;
      if (i == 0) checkValue("reqDrop", {31'd0, gpif.readData}, 32'd0);
    end
    gpif.fx3isReading = 1'b0;
    if (!aborted) begin
      mLast = n[15:0];
      mPkt = mPkt + 32'd1;
      if (n != PW) begin
        mLenE = 1;
        addError();
      end
      tick;
      checkValue("pktDone", {31'd0, packetDone}, 32'd1);
      checkValue("closeBusy", {31'd0, busy}, 32'd1);
      checkStatus("close");
    end
  endtask

  // Entered at the packetDone cycle; ends just after the next request rises.
  task automatic afterPacket(input bit park, input bit doClear);
    tick;
    checkValue("pktPulse", {31'd0, packetDone}, 32'd0);
    if (park) begin
      bufferReady = 1'b0;
      repeat (20) tick;
      checkValue("parkReadData", {31'd0, gpif.readData}, 32'd0);
      checkValue("parkBusy", {31'd0, busy}, 32'd0);
      if (doClear) begin
        clearErrors = 1'b1;
        tick;
        clearErrors = 1'b0;
        modelClear();
        checkStatus("clear");
      end
      bufferReady = 1'b1;
      tick;
      checkValue("parkRequest", {31'd0, gpif.readData}, 32'd1);
    end else begin
      // GAP_CYCLES in GAP plus one IDLE cycle from the packetDone edge; one edge already spent.
      waitRequest(GAP, "gapLength");
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int n;
    int ci;
    int cnt;
    logic [15:0] ca;
    bit park;

    modelReset();
    nReset = 1'b1;
    enable = 1'b0;
    bufferReady = 1'b0;
    clearErrors = 1'b0;
    gpif.fx3isReading = 1'b0;
    gpif.dataIn = 16'd0;
    #3 nReset = 1'b0;
    #2;
    checkValue("resetReadData", {31'd0, gpif.readData}, 32'd0);
    checkValue("resetBusy", {31'd0, busy}, 32'd0);
    checkValue("resetPacketDone", {31'd0, packetDone}, 32'd0);
    checkStatus("reset");
    tick;
    tick;
    enable = 1'b1;
    bufferReady = 1'b1;
    nReset = 1'b1;
    waitRequest(1, "firstRequest");

    // Clean full packet, short packet, corrupted full packet followed by a parked clear.
    sendPacket(PW, -1, 16'd0, -1);
    afterPacket(0, 0);
    sendPacket(100, -1, 16'd0, -1);
    afterPacket(0, 0);
    sendPacket(PW, 500, 16'd7, -1);
    afterPacket(1, 1);

    // Transmitter silent: request must time out after TMO cycles, then retry after the gap.
    cnt = 0;
    while (!timeoutError && cnt < 300) begin
      tick;
      cnt++;
    end
    checkValue("timeoutCycles", cnt, TMO);
    checkValue("timeoutReadData", {31'd0, gpif.readData}, 32'd0);
    mToE = 1;
    addError();
    checkStatus("timeout");
    waitRequest(GAP + 1, "timeoutRetry");

    // Random short packets with random corruption and random parking.
    for (int k = 0; k < 6; k++) begin
      n = int'($urandom_range(300, 1));
      if ($urandom_range(1, 0) == 1) ci = int'($urandom_range(n - 1, 0));
      else ci = -1;
      ca = 16'($urandom_range(65535, 1));
      park = 1'($urandom_range(1, 0));
      sendPacket(n, ci, ca, -1);
      afterPacket(park, 0);
    end

    // Stop requesting, then feed stray words in IDLE together with a clear: the new error wins, once.
    sendPacket(50, -1, 16'd0, -1);
    tick;
    enable = 1'b0;
    repeat (10) tick;
    checkValue("idleBusy", {31'd0, busy}, 32'd0);
    checkValue("idleReadData", {31'd0, gpif.readData}, 32'd0);
    gpif.fx3isReading = 1'b1;
    gpif.dataIn = 16'h1234;
    clearErrors = 1'b1;
    tick;
    clearErrors = 1'b0;
    repeat (3) tick;
    gpif.fx3isReading = 1'b0;
    modelClear();
    mLenE = 1;
    addError();
    checkStatus("stray");
    enable = 1'b1;
    tick;
    checkValue("resumeRequest", {31'd0, gpif.readData}, 32'd1);

    // Shared reset pulsed mid-packet, then a full clean packet from the restarted pattern.
    sendPacket(PW, -1, 16'd0, 4000);
    waitRequest(1, "postResetRequest");
    sendPacket(PW, -1, 16'd0, -1);
    afterPacket(0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
